// File: rtl/buffer_ram_arbiter.sv
// Round-robin arbiter sharing one 1R1W buffer RAM between read and write requesters.
// Read responses are steered back by a valid/ID pipeline matched to the RAM read latency.
module buffer_ram_arbiter #(
  parameter int NUM_RD       = 4,
  parameter int NUM_WR       = 2,
  parameter int DEPTH        = 512,
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 3,
  parameter int WR_FIRST     = 1,
  parameter int DEPTHAD      = $clog2(DEPTH),
  parameter int IDW          = (NUM_RD > 1) ? $clog2(NUM_RD) : 1,
  localparam int WPW         = (NUM_WR > 1) ? $clog2(NUM_WR) : 1,
  localparam int CNTW        = $clog2(READ_LATENCY + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_RD-1:0]         rd_req,
  input  logic [NUM_RD*DEPTHAD-1:0] rd_addr,
  output logic [NUM_RD-1:0]         rd_gnt,
  output logic [NUM_RD-1:0]         rd_rvalid,
  output logic [WIDTH-1:0]          rd_rdata,
  input  logic [NUM_WR-1:0]         wr_req,
  input  logic [NUM_WR*DEPTHAD-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]   wr_data,
  output logic [NUM_WR-1:0]         wr_gnt,
  output logic [DEPTHAD-1:0]        ram_raddr,
  output logic [DEPTHAD-1:0]        ram_waddr,
  output logic [WIDTH-1:0]          ram_wdata,
  output logic                      ram_wren,
  input  logic [WIDTH-1:0]          ram_rdata,
  output logic                      busy,
  output logic [CNTW-1:0]           inflight
);

  // Handshake: a requester holds req and addr/data stable; a transfer happens in the
  // cycle where req and the combinational gnt are both high. Dropping req early is legal.

  logic [DEPTHAD-1:0] rd_addr_a [NUM_RD];
  logic [DEPTHAD-1:0] wr_addr_a [NUM_WR];
  logic [WIDTH-1:0]   wr_data_a [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign rd_addr_a[i] = rd_addr[i*DEPTHAD +: DEPTHAD];
  end
  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign wr_addr_a[i] = wr_addr[i*DEPTHAD +: DEPTHAD];
    assign wr_data_a[i] = wr_data[i*WIDTH +: WIDTH];
  end

  logic [WPW-1:0]    wr_ptr;
  logic [IDW-1:0]    rd_ptr;
  logic              wr_found, rd_found, wr_fire, rd_fire;
  logic [WPW-1:0]    wr_win;
  logic [IDW-1:0]    rd_win;
  logic [NUM_RD-1:0] rd_cand;
  logic [DEPTHAD-1:0] raddr_q;
  logic [READ_LATENCY-1:0] pv;
  logic [IDW-1:0]    pid [READ_LATENCY];
  logic [CNTW-1:0]   cnt;
  logic              resp;

  always_comb begin : wr_arb
    logic [WPW-1:0] idx;
    idx      = '0;
    wr_found = 1'b0;
    wr_win   = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      idx = WPW'((int'(wr_ptr) + i) % NUM_WR);
      if (!wr_found && wr_req[idx]) begin
        wr_found = 1'b1;
        wr_win   = idx;
      end
    end
  end

  assign wr_fire   = wr_found & rstn;
  assign ram_wren  = wr_fire;
  assign ram_waddr = wr_addr_a[wr_win];
  assign ram_wdata = wr_data_a[wr_win];

  // A read colliding with this cycle's write is masked so it observes the new data next cycle.
  always_comb begin
    rd_cand = rd_req;
    for (int i = 0; i < NUM_RD; i++) begin
      if (WR_FIRST != 0 && ram_wren && rd_addr_a[i] == ram_waddr) rd_cand[i] = 1'b0;
    end
  end

  always_comb begin : rd_arb
    logic [IDW-1:0] idx;
    idx      = '0;
    rd_found = 1'b0;
    rd_win   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      idx = IDW'((int'(rd_ptr) + i) % NUM_RD);
      if (!rd_found && rd_cand[idx]) begin
        rd_found = 1'b1;
        rd_win   = idx;
      end
    end
  end

  assign rd_fire   = rd_found & rstn;
  assign ram_raddr = rd_fire ? rd_addr_a[rd_win] : raddr_q;

  always_comb begin
    rd_gnt = '0;
    wr_gnt = '0;
    if (rd_fire) rd_gnt[rd_win] = 1'b1;
    if (wr_fire) wr_gnt[wr_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      raddr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr <= WPW'((int'(wr_win) + 1) % NUM_WR);
      if (rd_fire) rd_ptr <= IDW'((int'(rd_win) + 1) % NUM_RD);
      raddr_q <= ram_raddr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pid[k] <= '0;
    end else begin
      pv[0]  <= rd_fire;
      pid[0] <= rd_win;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end

  assign resp = pv[READ_LATENCY-1];

  always_comb begin
    rd_rvalid = '0;
    if (rstn && resp) rd_rvalid[pid[READ_LATENCY-1]] = 1'b1;
  end

  assign rd_rdata = ram_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (rd_fire && !resp) cnt <= cnt + CNTW'(1);
    else if (!rd_fire && resp) cnt <= cnt - CNTW'(1);
  end

  assign inflight = cnt;
  assign busy     = rstn & ((|rd_req) | (|wr_req) | (cnt != '0));

endmodule

// File: tb/tb_buffer_ram_arbiter.sv
// Directed bench for buffer_ram_arbiter: one write-first instance and one read-first
// instance, each with its own behavioural RAM of fixed read latency.
module tb_buffer_ram_arbiter;

  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int DEPTH = 512;
  localparam int W = 32;
  localparam int LAT = 3;
  localparam int AW = 9;
  localparam int CW = 2;

  logic clk, rstn;
  logic [NRD-1:0] rd_req, rd_req_b;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0] wr_req;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*W-1:0] wr_data;

  logic [NRD-1:0] rd_gnt, rd_rvalid, rd_gnt_b, rd_rvalid_b;
  logic [W-1:0] rd_rdata, rd_rdata_b, ram_wdata, ram_wdata_b, ram_rdata, ram_rdata_b;
  logic [NWR-1:0] wr_gnt, wr_gnt_b;
  logic [AW-1:0] ram_raddr, ram_waddr, ram_raddr_b, ram_waddr_b;
  logic ram_wren, ram_wren_b, busy, busy_b;
  logic [CW-1:0] inflight, inflight_b;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  buffer_ram_arbiter #(.NUM_RD(NRD), .NUM_WR(NWR), .DEPTH(DEPTH), .WIDTH(W),
                       .READ_LATENCY(LAT), .WR_FIRST(1)) u_dut (
    .clk(clk), .rstn(rstn), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata), .busy(busy),
    .inflight(inflight));

  buffer_ram_arbiter #(.NUM_RD(NRD), .NUM_WR(NWR), .DEPTH(DEPTH), .WIDTH(W),
                       .READ_LATENCY(LAT), .WR_FIRST(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .rd_req(rd_req_b), .rd_addr(rd_addr), .rd_gnt(rd_gnt_b),
    .rd_rvalid(rd_rvalid_b), .rd_rdata(rd_rdata_b), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt_b), .ram_raddr(ram_raddr_b), .ram_waddr(ram_waddr_b),
    .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b), .ram_rdata(ram_rdata_b), .busy(busy_b),
    .inflight(inflight_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAMs: read returns pre-write data, LAT cycles after the address
  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];
  logic [W-1:0] pipe_a [LAT];
  logic [W-1:0] pipe_b [LAT];

  always @(posedge clk) begin
    if (ram_wren) mem_a[ram_waddr] <= ram_wdata;
    if (ram_wren_b) mem_b[ram_waddr_b] <= ram_wdata_b;
    pipe_a[0] <= mem_a[ram_raddr];
    pipe_b[0] <= mem_b[ram_raddr_b];
    for (int k = 1; k < LAT; k++) begin
      pipe_a[k] <= pipe_a[k-1];
      pipe_b[k] <= pipe_b[k-1];
    end
  end
  assign ram_rdata = pipe_a[LAT-1];
  assign ram_rdata_b = pipe_b[LAT-1];

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_wr(input int i, input int a, input int d);
    wr_addr[i*AW +: AW] = a[AW-1:0];
    wr_data[i*W +: W] = d[W-1:0];
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    rd_req = '0;
    rd_req_b = '0;
    wr_req = '0;
    #3;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rd_req = '1;
    wr_req = '1;
    #2;
    checks++; if (rd_gnt !== 4'b0) begin failures++; $display("FAIL reset_rd_gnt got=%b exp=0000", rd_gnt); end
    checks++; if (wr_gnt !== 2'b0) begin failures++; $display("FAIL reset_wr_gnt got=%b exp=00", wr_gnt); end
    checks++; if (rd_rvalid !== 4'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rd_rvalid); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", ram_wren); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (inflight !== 2'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    rd_req = '0;
    wr_req = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_preload();
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      wr_req = 2'b01;
      if (k < 8) set_wr(0, k, 100 + k);
      else set_wr(0, 9, 'h55);
      #1;
      checks++; if (wr_gnt !== 2'b01) begin failures++; $display("FAIL preload_gnt k=%0d got=%b exp=01", k, wr_gnt); end
      checks++;
      if (ram_wdata !== ((k < 8) ? W'(100 + k) : W'('h55))) begin
        failures++; $display("FAIL preload_wdata k=%0d got=%0d", k, ram_wdata);
      end
    end
    next_cycle();
    wr_req = '0;
  endtask

  task automatic test_single_read();
    next_cycle();
    rd_req = 4'b0100;
    set_rd(2, 5);
    #1;
    checks++; if (rd_gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", rd_gnt); end
    checks++; if (ram_raddr !== 9'd5) begin failures++; $display("FAIL single_raddr got=%0d exp=5", ram_raddr); end
    for (int c = 1; c <= LAT; c++) begin
      next_cycle();
      rd_req = '0;
      #1;
      if (c == 1) begin
        checks++; if (inflight !== 2'd1) begin failures++; $display("FAIL single_inflight got=%0d exp=1", inflight); end
      end
      if (c < LAT) begin
        checks++; if (rd_rvalid !== 4'b0) begin failures++; $display("FAIL single_early c=%0d got=%b exp=0000", c, rd_rvalid); end
      end else begin
        checks++; if (rd_rvalid !== 4'b0100) begin failures++; $display("FAIL single_rvalid got=%b exp=0100", rd_rvalid); end
        checks++; if (rd_rdata !== 32'd105) begin failures++; $display("FAIL single_rdata got=%0d exp=105", rd_rdata); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_gnt, e_rv;
    int e_inf;
    logic [W-1:0] e_dat;
    apply_reset();
    for (int i = 0; i < NRD; i++) set_rd(i, i);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      rd_req = (c < 8) ? 4'hf : 4'h0;
      #1;
      e_gnt = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
      e_rv = (c >= 3 && c < 11) ? 4'(1 << ((c - 3) % 4)) : 4'b0;
      e_inf = (c < 8) ? ((c < 3) ? c : 3) : 11 - c;
      checks++; if (rd_gnt !== e_gnt) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, rd_gnt, e_gnt); end
      if (c < 8) begin
        exp_q.push_back(W'(100 + c % 4));
        checks++; if (ram_raddr !== AW'(c % 4)) begin failures++; $display("FAIL rr_raddr c=%0d got=%0d exp=%0d", c, ram_raddr, c % 4); end
      end
      checks++; if (rd_rvalid !== e_rv) begin failures++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, rd_rvalid, e_rv); end
      if (e_rv != 4'b0 && exp_q.size() > 0) begin
        e_dat = exp_q.pop_front();
        checks++; if (rd_rdata !== e_dat) begin failures++; $display("FAIL rr_rdata c=%0d got=%0d exp=%0d", c, rd_rdata, e_dat); end
      end
      checks++; if (inflight !== CW'(e_inf)) begin failures++; $display("FAIL rr_inflight c=%0d got=%0d exp=%0d", c, inflight, e_inf); end
      checks++; if (busy !== (c < 8 || e_inf != 0)) begin failures++; $display("FAIL rr_busy c=%0d got=%b", c, busy); end
    end
    exp_q.delete();
  endtask

  task automatic test_writers();
    int j0, j1;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      wr_req = 2'b11;
      j0 = (c + 1) / 2;
      j1 = c / 2;
      set_wr(0, 16 + 2 * j0, 200 + 2 * j0);
      set_wr(1, 17 + 2 * j1, 201 + 2 * j1);
      #1;
      checks++; if (wr_gnt !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL wr_gnt c=%0d got=%b", c, wr_gnt); end
      checks++; if (ram_waddr !== AW'(16 + c)) begin failures++; $display("FAIL wr_waddr c=%0d got=%0d exp=%0d", c, ram_waddr, 16 + c); end
      checks++; if (ram_wdata !== W'(200 + c)) begin failures++; $display("FAIL wr_wdata c=%0d got=%0d exp=%0d", c, ram_wdata, 200 + c); end
    end
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      wr_req = '0;
      rd_req = (c < 4) ? 4'b0001 : 4'b0000;
      if (c < 4) set_rd(0, 16 + c);
      #1;
      if (c < 4) begin
        checks++; if (rd_gnt !== 4'b0001) begin failures++; $display("FAIL wrrb_gnt c=%0d got=%b exp=0001", c, rd_gnt); end
      end
      if (c >= 3) begin
        checks++; if (rd_rvalid !== 4'b0001) begin failures++; $display("FAIL wrrb_rvalid c=%0d got=%b exp=0001", c, rd_rvalid); end
        checks++; if (rd_rdata !== W'(200 + c - 3)) begin failures++; $display("FAIL wrrb_rdata c=%0d got=%0d exp=%0d", c, rd_rdata, 200 + c - 3); end
      end
    end
    next_cycle();
    rd_req = '0;
  endtask

  task automatic test_wr_first();
    apply_reset();
    next_cycle();
    wr_req = 2'b01;
    set_wr(0, 9, 'hAA);
    set_rd(1, 9);
    set_rd(3, 4);
    rd_req = 4'b1010;
    rd_req_b = 4'b1010;
    #1;
    checks++; if (ram_wren !== 1'b1) begin failures++; $display("FAIL wf_wren got=%b exp=1", ram_wren); end
    checks++; if (rd_gnt !== 4'b1000) begin failures++; $display("FAIL wf_mask_gnt got=%b exp=1000", rd_gnt); end
    checks++; if (ram_raddr !== 9'd4) begin failures++; $display("FAIL wf_raddr got=%0d exp=4", ram_raddr); end
    checks++; if (rd_gnt_b !== 4'b0010) begin failures++; $display("FAIL rf_gnt got=%b exp=0010", rd_gnt_b); end
    checks++; if (ram_raddr_b !== 9'd9) begin failures++; $display("FAIL rf_raddr got=%0d exp=9", ram_raddr_b); end
    next_cycle();
    wr_req = '0;
    rd_req = 4'b0010;
    rd_req_b = '0;
    #1;
    checks++; if (rd_gnt !== 4'b0010) begin failures++; $display("FAIL wf_retry_gnt got=%b exp=0010", rd_gnt); end
    checks++; if (ram_raddr !== 9'd9) begin failures++; $display("FAIL wf_retry_raddr got=%0d exp=9", ram_raddr); end
    next_cycle();
    rd_req = '0;
    next_cycle();
    #1;
    checks++; if (rd_rvalid !== 4'b1000) begin failures++; $display("FAIL wf_rv3 got=%b exp=1000", rd_rvalid); end
    checks++; if (rd_rdata !== 32'd104) begin failures++; $display("FAIL wf_rd3 got=%0d exp=104", rd_rdata); end
    checks++; if (rd_rvalid_b !== 4'b0010) begin failures++; $display("FAIL rf_rv got=%b exp=0010", rd_rvalid_b); end
    checks++; if (rd_rdata_b !== 32'h55) begin failures++; $display("FAIL rf_rdata got=%h exp=55", rd_rdata_b); end
    next_cycle();
    #1;
    checks++; if (rd_rvalid !== 4'b0010) begin failures++; $display("FAIL wf_rv1 got=%b exp=0010", rd_rvalid); end
    checks++; if (rd_rdata !== 32'hAA) begin failures++; $display("FAIL wf_rd1 got=%h exp=aa", rd_rdata); end
    checks++; if (rd_rvalid_b !== 4'b0) begin failures++; $display("FAIL rf_rv_extra got=%b exp=0000", rd_rvalid_b); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    next_cycle();
    rd_req = 4'b0001;
    set_rd(0, 1);
    #1;
    checks++; if (rd_gnt !== 4'b0001) begin failures++; $display("FAIL mid_gnt0 got=%b exp=0001", rd_gnt); end
    next_cycle();
    rd_req = 4'b0010;
    set_rd(1, 2);
    #1;
    checks++; if (rd_gnt !== 4'b0010) begin failures++; $display("FAIL mid_gnt1 got=%b exp=0010", rd_gnt); end
    next_cycle();
    rd_req = '0;
    #1;
    checks++; if (inflight !== 2'd2) begin failures++; $display("FAIL mid_inflight got=%0d exp=2", inflight); end
    rd_req = 4'hf;
    wr_req = 2'b01;
    rstn = 1'b0;
    #1;
    checks++; if (rd_gnt !== 4'b0) begin failures++; $display("FAIL mid_rst_gnt got=%b exp=0000", rd_gnt); end
    checks++; if (wr_gnt !== 2'b0) begin failures++; $display("FAIL mid_rst_wgnt got=%b exp=00", wr_gnt); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL mid_rst_wren got=%b exp=0", ram_wren); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (inflight !== 2'd0) begin failures++; $display("FAIL mid_rst_inflight got=%0d exp=0", inflight); end
    rd_req = '0;
    wr_req = '0;
    next_cycle();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #1;
      checks++; if (rd_rvalid !== 4'b0) begin failures++; $display("FAIL mid_ghost c=%0d got=%b exp=0000", c, rd_rvalid); end
      checks++; if (inflight !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle c=%0d inflight=%0d busy=%b exp=0/0", c, inflight, busy); end
    end
    next_cycle();
    rd_req = 4'hf;
    for (int i = 0; i < NRD; i++) set_rd(i, i);
    #1;
    checks++; if (rd_gnt !== 4'b0001) begin failures++; $display("FAIL mid_first_gnt got=%b exp=0001", rd_gnt); end
    next_cycle();
    rd_req = '0;
    repeat (LAT + 1) next_cycle();
  endtask

  initial begin
    rstn = 1'b0;
    rd_req = '0;
    rd_req_b = '0;
    rd_addr = '0;
    wr_req = '0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_preload();
    test_single_read();
    test_round_robin();
    test_writers();
    test_wr_first();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_ram_arbiter.md
Name: buffer_ram_arbiter

Overview:
- Shares one 1R1W BufferRAM-style memory (fixed READ_LATENCY, registered read pipeline) between NUM_RD read requesters and NUM_WR write requesters.
- Round-robin arbitration on each port. Tracks in-flight reads in a valid/ID pipeline so every read response is steered back to its issuing requester exactly READ_LATENCY cycles after acceptance.
- Sits between FHE ALU lanes and a shared coefficient/twiddle buffer.

Parameters:
- NUM_RD, 4, number of read requesters (>=1)
- NUM_WR, 2, number of write requesters (>=1)
- DEPTH, 512, RAM depth in words
- WIDTH, FSIZE, data word width
- READ_LATENCY, BUFFER_READ_LATENCY, RAM read latency in cycles (>=1)
- WR_FIRST, 1, if 1, stall a read whose address equals the same-cycle granted write address
- DEPTHAD, $clog2(DEPTH), address width
- IDW, $clog2(NUM_RD) (min 1), read-ID width

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- rd_req  in  NUM_RD  per-requester read request
- rd_addr  in  NUM_RD*DEPTHAD  flattened read addresses; requester i at bits [i*DEPTHAD +: DEPTHAD]
- rd_gnt  out  NUM_RD  one-hot read grant; combinational, same cycle as request
- rd_rvalid  out  NUM_RD  one-hot response valid
- rd_rdata  out  WIDTH  response data, broadcast to all requesters
- wr_req  in  NUM_WR  per-requester write request
- wr_addr  in  NUM_WR*DEPTHAD  flattened write addresses
- wr_data  in  NUM_WR*WIDTH  flattened write data
- wr_gnt  out  NUM_WR  one-hot write grant; combinational
- ram_raddr  out  DEPTHAD  to RAM read address
- ram_waddr  out  DEPTHAD  to RAM write address
- ram_wdata  out  WIDTH  to RAM write data
- ram_wren  out  1  to RAM write enable
- ram_rdata  in  WIDTH  from RAM read data (READ_LATENCY after raddr)
- busy  out  1  1 while any read is in flight or any request is pending
- inflight  out  $clog2(READ_LATENCY+1)  count of accepted reads not yet returned

Behaviour:
- Reset (rstn=0, async): RR pointers rd_ptr=0 and wr_ptr=0; valid/ID pipeline cleared; inflight=0.
- Outputs during reset: rd_gnt=0, wr_gnt=0, rd_rvalid=0, ram_wren=0, busy=0.
- Reset asserted mid-operation drops all in-flight responses; no rd_rvalid for them after release.
- Write arbitration: grant goes to the first requester at or after wr_ptr (wrapping) with wr_req=1.
  - Same cycle: ram_wren=1, ram_waddr/ram_wdata muxed from the winner.
  - On a grant, wr_ptr <= winner+1 mod NUM_WR. No request: ram_wren=0, pointer holds.
- Read arbitration: same RR scheme on rd_ptr. Candidates are requesters with rd_req=1.
  - If WR_FIRST=1 and ram_wren=1, requesters whose address equals ram_waddr are masked out this cycle.
  - A masked requester keeps its place and retries next cycle.
  - Winner gets rd_gnt; ram_raddr = winner address.
  - With no grant, ram_raddr holds its previous value (registered copy); no response is tracked.
- Response pipeline: a shift register of depth READ_LATENCY carrying {valid, id}.
  - Stage 0 is loaded at the grant edge.
  - rd_rvalid[id] asserts exactly READ_LATENCY cycles after the grant cycle, aligned with ram_rdata; rd_rdata = ram_rdata.
  - One grant per cycle gives full throughput: back-to-back grants produce back-to-back responses.
- inflight: +1 on grant, -1 on response, both in the same cycle leaves it unchanged. Never exceeds READ_LATENCY.
- busy = |rd_req | |wr_req | (inflight != 0).
- Read/write to the same address in the same cycle with WR_FIRST=0: the read returns pre-write data.
- Requesters hold req and addr stable until granted. Dropping req before grant is legal; no transaction occurs.
- Single requester (NUM_RD=1 or NUM_WR=1): the pointer stays at 0 and grant = req.

Test Plan:
- Reset, then preload via write port 0: addr k data 100+k for k=0..7. Reader 2 reads addr 5 -> rd_gnt=4'b0100 same cycle; rd_rvalid=4'b0100 with rd_rdata=105 exactly READ_LATENCY cycles later.
- All 4 readers request continuously at distinct addresses -> grants rotate 0,1,2,3,0 one per cycle; responses return in the same order, one per cycle; inflight saturates at READ_LATENCY.
- Both writers request continuously -> wr_gnt alternates 01,10,01; each write lands at its address (verified by readback).
- WR_FIRST=1: writer 0 writes addr 9 (data 0xAA, old 0x55) while reader 1 (addr 9) and reader 3 (addr 4) request -> reader 1 masked, reader 3 granted. Reader 1 granted next cycle and receives 0xAA.
- WR_FIRST=0, same stimulus -> reader 1 granted in the write cycle and receives 0x55.
- Assert rstn=0 with 2 reads in flight -> outputs cleared immediately. After release: no rd_rvalid, inflight=0, busy=0, first new grant goes to requester 0.
